// File: rtl/aes128_decrypt_iter.sv
// rtl/aes128_decrypt_iter.sv - iterative AES-128 decryptor, key schedule expanded one word-group per cycle
// Optional AES_DEC_KEY_CACHE_EN reuses the last expanded schedule when the key repeats.
module aes128_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         busy
);
   typedef enum logic [2:0] {IDLE, KEXP, ROUND, FINAL, DONE} state_t;

   state_t       state;
   logic [3:0]   round;
   logic [127:0] st;
   logic [127:0] ct_reg;
   logic [127:0] rk [0:10];
   logic [127:0] kexp_next;
   logic [127:0] round_out;
`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] cached_key;
   logic         cache_valid;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box requires)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t;
      logic [31:0] w0, w1, w2, w3;
      t  = {k[23:0], k[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Byte i of the state is row i%4, column i/4
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rkey,
                                              input logic mix);
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r)&3)+r) -: 8]);
      t = t ^ rkey;
      if (mix) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            t[127-32*c -: 32] = {
               gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
               gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
               gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
               gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
         end
      end
      return t;
   endfunction

   assign kexp_next = next_key(rk[round - 4'd1], rcon(round));
   assign round_out = inv_round(st, (state == FINAL) ? rk[0] : rk[round], state != FINAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         plaintext <= '0;
         round     <= '0;
         st        <= '0;
         ct_reg    <= '0;
         for (int i = 0; i < 11; i++) rk[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
         cached_key  <= '0;
         cache_valid <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               busy     <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
               if (cache_valid && key == cached_key) begin
                  st    <= ciphertext ^ rk[10];
                  round <= 4'd9;
                  state <= ROUND;
               end else begin
                  cache_valid <= 1'b0;
                  rk[0]       <= key;
                  ct_reg      <= ciphertext;
                  round       <= 4'd1;
                  state       <= KEXP;
               end
`else
               rk[0]  <= key;
               ct_reg <= ciphertext;
               round  <= 4'd1;
               state  <= KEXP;
`endif
            end
            KEXP: begin
               rk[round] <= kexp_next;
               if (round == 4'd10) begin
                  st    <= ct_reg ^ kexp_next;
                  round <= 4'd9;
                  state <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                  cached_key  <= rk[0];
                  cache_valid <= 1'b1;
`endif
               end else begin
                  round <= round + 4'd1;
               end
            end
            ROUND: begin
               st    <= round_out;
               round <= round - 4'd1;
               if (round == 4'd1) state <= FINAL;
            end
            FINAL: begin
               plaintext <= round_out;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb/tb_aes128_decrypt_iter.sv - randomized self-checking bench against a table-driven AES inverse cipher model
module tb_aes128_decrypt_iter;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] ciphertext = '0;
   logic [127:0] key = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] plaintext;

   aes128_decrypt_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ciphertext(ciphertext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
      .plaintext(plaintext), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit cache_en = 1'b1;
`else
   localparam bit cache_en = 1'b0;
`endif

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   logic [7:0] sb [0:255];
   logic [7:0] isb [0:255];
   logic [7:0] gexp [0:255];
   int         glog [0:255];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 0 || b == 0) return 8'h00;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction

   task automatic build_tables();
      logic [7:0] p, inv, b, c;
      p = 8'h01;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = p;
         glog[p] = i;
         p = p ^ xt(p);
      end
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : gexp[(255 - glog[x]) % 255];
         for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x]  = b;
         isb[b] = x[7:0];
      end
   endtask

   function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
      logic [31:0]  w [0:43];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [0:3][0:3];
      logic [7:0]   t [0:3][0:3];
      logic [7:0]   circ [0:3];
      logic [127:0] res;
      circ[0] = 8'h0e; circ[1] = 8'h0b; circ[2] = 8'h0d; circ[3] = 8'h09;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[40+c][31-8*r -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = isb[s[r][(c - r + 4) % 4]] ^ w[4*rnd+c][31-8*r -: 8];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (rnd == 0) s[r][c] = t[r][c];
               else s[r][c] = gmul(t[0][c], circ[(4-r)%4]) ^ gmul(t[1][c], circ[(5-r)%4])
                            ^ gmul(t[2][c], circ[(6-r)%4]) ^ gmul(t[3][c], circ[(7-r)%4]);
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   logic [127:0] exp_pt [0:63];
   int           exp_done [0:63];
   int           n_issued = 0;
   int           rd = 0;
   int           checks = 0;
   int           errors = 0;
   bit           pinned = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (cyc == 3 && !pinned) begin
         pinned = 1'b1;
         chk("model_sbox0", {120'h0, sb[0]}, 128'h63);
         chk("model_isbox0", {120'h0, isb[0]}, 128'h52);
         chk("model_vec1", model_decrypt(C1, K1), P1);
         chk("model_vec2", model_decrypt(C2, K2), P2);
      end
      if (!rst_n) begin
         chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
         chk("rst_busy", {127'h0, busy}, 128'h0);
         chk("rst_plaintext", plaintext, 128'h0);
         rd = n_issued;
      end else begin
         chk("ready_vs_busy", {127'h0, in_ready}, {127'h0, !busy});
         chk("ready_and_valid", {127'h0, in_ready & out_valid}, 128'h0);
         if (rd < n_issued) begin
            chk("busy_in_job", {127'h0, busy}, 128'h1);
            chk("out_valid_timing", {127'h0, out_valid}, {127'h0, cyc >= exp_done[rd]});
            if (out_valid) chk("plaintext", plaintext, exp_pt[rd]);
            if (out_valid && out_ready) rd++;
         end else begin
            chk("idle_busy", {127'h0, busy}, 128'h0);
            chk("idle_out_valid", {127'h0, out_valid}, 128'h0);
            chk("idle_in_ready", {127'h0, in_ready}, 128'h1);
         end
      end
   end

   bit           m_cache_ok = 1'b0;
   logic [127:0] m_cache_key = '0;
   logic [127:0] cur_key = '0;

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      m_cache_ok = 1'b0;
   endtask

   task automatic issue(input logic [127:0] c, input logic [127:0] k);
      int lat;
      for (int i = 0; i < 50 && !in_ready; i++) begin @(posedge clk); #1; end
      ciphertext = c;
      key        = k;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = (cache_en && m_cache_ok && k == m_cache_key) ? 10 : 20;
      if (lat == 20) m_cache_ok = 1'b0;
      exp_pt[n_issued]   = model_decrypt(c, k);
      exp_done[n_issued] = cyc + lat;
      n_issued++;
      cur_key = k;
   endtask

   task automatic spam_inputs(input bit spam);
      if (spam) begin
         in_valid   = 1'($urandom_range(0, 1));
         ciphertext = {$urandom, $urandom, $urandom, $urandom};
         key        = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic finish_job(input int hold, input bit spam);
      int n;
      n = 0;
      while (!out_valid && n < 60) begin
         spam_inputs(spam);
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) begin
         do_reset();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         spam_inputs(spam);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready   = 1'b0;
      in_valid    = 1'b0;
      m_cache_ok  = 1'b1;
      m_cache_key = cur_key;
   endtask

   logic [127:0] pool [0:2];

   initial begin
      build_tables();
      for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      issue(C1, K1); finish_job(0, 1'b0);
      issue(C2, K2); finish_job(5, 1'b0);

      issue(C1, K1);
      repeat (6) begin @(posedge clk); #1; end
      do_reset();
      issue(C1, K1); finish_job(1, 1'b0);

      issue(C2, K2); finish_job(0, 1'b1);
      issue({$urandom, $urandom, $urandom, $urandom}, K2); finish_job(2, 1'b1);

      for (int j = 0; j < 10; j++) begin
         issue({$urandom, $urandom, $urandom, $urandom}, pool[$urandom_range(0, 2)]);
         finish_job($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      issue(C1, {$urandom, $urandom, $urandom, $urandom}); finish_job(0, 1'b1);
      issue(C1, K1); finish_job(0, 1'b0);

      repeat (3) @(posedge clk);
      #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
      $fatal(1);
   end
endmodule
